// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per cycle; divide-by-zero and signed overflow finish without iterating.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_opa,
    input  logic [WIDTH-1:0] i_opb,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_sel_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;

    logic             w_accept;
    logic             w_signed;
    logic             w_div_zero;
    logic             w_ovf;
    logic             w_special;
    logic [WIDTH-1:0] w_special_res;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_last;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;
    logic [WIDTH-1:0] w_rem_fin;
    logic [WIDTH-1:0] w_quo_fin;
    logic [WIDTH-1:0] w_calc_res;

    // Flush wins over start; start is only honoured outside CALC.
    assign w_accept   = (r_state != CALC) && i_start && !i_flush;
    assign w_signed   = ~i_op[0];
    assign w_div_zero = (i_opb == '0);
    assign w_ovf      = w_signed && (i_opa == MIN_NEG) && (i_opb == '1);
    assign w_special  = w_div_zero || w_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = i_op[1] ? i_opa : '1;
        end else begin
            w_special_res = i_op[1] ? '0 : MIN_NEG;
        end
    end

    assign w_a_mag = (w_signed && i_opa[WIDTH-1]) ? -i_opa : i_opa;
    assign w_b_mag = (w_signed && i_opb[WIDTH-1]) ? -i_opb : i_opb;

    // Shifted partial remainder needs one extra bit when the divisor magnitude uses the MSB.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_div});
    assign w_sub      = w_shift[WIDTH-1:0] - r_div;
    assign w_rem_nx   = w_ge ? w_sub : w_shift[WIDTH-1:0];
    assign w_quo_nx   = {r_quo[WIDTH-2:0], w_ge};
    assign w_rem_fin  = r_neg_r ? -w_rem_nx : w_rem_nx;
    assign w_quo_fin  = r_neg_q ? -w_quo_nx : w_quo_nx;
    assign w_calc_res = r_sel_rem ? w_rem_fin : w_quo_fin;
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    w_next = w_special ? DONE : CALC;
                end else begin
                    w_next = IDLE;
                end
            end
            CALC: begin
                if (i_flush) begin
                    w_next = IDLE;
                end else if (w_last) begin
                    w_next = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sel_rem <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
        end else if (w_accept) begin
            r_sel_rem <= i_op[1];
            r_neg_q   <= w_signed && (i_opa[WIDTH-1] ^ i_opb[WIDTH-1]);
            r_neg_r   <= w_signed && i_opa[WIDTH-1];
            r_div     <= w_b_mag;
            r_rem     <= '0;
            r_quo     <= w_a_mag;
            r_cnt     <= '0;
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if ((r_state == CALC) && !i_flush) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_result <= w_calc_res;
            end
        end
    end

    assign o_busy   = (r_state == CALC);
    assign o_done   = (r_state == DONE);
    assign o_result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: arithmetic, special cases, flush, reset, back-to-back.
module tb_div_unit;

    logic        clk;
    logic        nrst;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_opa;
    logic [31:0] i_opb;
    logic        i_flush;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .i_start  (i_start),
        .i_op     (i_op),
        .i_opa    (i_opa),
        .i_opb    (i_opb),
        .i_flush  (i_flush),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result (o_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the done cycle.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit special);
        int bad;
        i_op    = op;
        i_opa   = a;
        i_opb   = b;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        if (!special) begin
            bad = 0;
            for (int c = 1; c <= 32; c++) begin
                if (!(o_busy === 1'b1 && o_done === 1'b0)) bad++;
                @(negedge clk);
            end
            check({tag, " busy window"}, 32'(bad), 32'd0);
        end
        check({tag, " done"}, {31'd0, o_done}, 32'd1);
        check({tag, " busy"}, {31'd0, o_busy}, 32'd0);
        check({tag, " result"}, o_result, exp);
    endtask

    initial begin
        int seen_done;
        nrst    = 1'b1;
        i_start = 1'b0;
        i_op    = 2'b00;
        i_opa   = '0;
        i_opb   = '0;
        i_flush = 1'b0;
        #1 nrst = 1'b0;
        #2;
        check("reset busy", {31'd0, o_busy}, 32'd0);
        check("reset done", {31'd0, o_done}, 32'd0);
        check("reset result", o_result, 32'd0);
        @(negedge clk);
        nrst = 1'b1;

        do_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
        @(negedge clk);
        check("single done pulse", {31'd0, o_done}, 32'd0);
        do_op("remu 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0);
        // Back-to-back: issued in the DONE cycle of the previous op.
        do_op("div -7/2 b2b", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        @(negedge clk);
        do_op("rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        do_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        @(negedge clk);
        do_op("rem 7/-2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
        @(negedge clk);
        do_op("divu 5/0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        do_op("rem 5/0", OP_REM, 32'd5, 32'd0, 32'd5, 1'b1);
        do_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        do_op("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
        @(negedge clk);
        check("after specials done", {31'd0, o_done}, 32'd0);
        do_op("divu big", OP_DIVU, 32'h1234_5678, 32'h100, 32'h0012_3456, 1'b0);
        @(negedge clk);

        // Flush in IDLE suppresses a simultaneous start.
        i_op    = OP_DIVU;
        i_opa   = 32'd9;
        i_opb   = 32'd0;
        i_start = 1'b1;
        i_flush = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_flush = 1'b0;
        check("idle flush busy", {31'd0, o_busy}, 32'd0);
        check("idle flush done", {31'd0, o_done}, 32'd0);
        @(negedge clk);

        // Flush mid-CALC, with an ignored start at cycle 5.
        i_op      = OP_DIVU;
        i_opa     = 32'd1000;
        i_opb     = 32'd3;
        i_start   = 1'b1;
        seen_done = 0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (o_done !== 1'b0) seen_done++;
            if (c == 10) check("busy before flush", {31'd0, o_busy}, 32'd1);
            case (c)
                1:  i_start = 1'b0;
                5:  begin i_start = 1'b1; i_opb = 32'd0; end
                6:  begin i_start = 1'b0; i_opb = 32'd3; end
                10: i_flush = 1'b1;
                11: i_flush = 1'b0;
                default: ;
            endcase
        end
        check("flush no done", 32'(seen_done), 32'd0);
        check("flush busy", {31'd0, o_busy}, 32'd0);
        check("flush result kept", o_result, 32'h0012_3456);
        @(negedge clk);
        do_op("divu 1000/3", OP_DIVU, 32'd1000, 32'd3, 32'd333, 1'b0);
        @(negedge clk);

        // Asynchronous reset mid-CALC.
        i_op    = OP_DIVU;
        i_opa   = 32'd1000;
        i_opb   = 32'd7;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (19) @(negedge clk);
        check("pre-reset busy", {31'd0, o_busy}, 32'd1);
        #2 nrst = 1'b0;
        #1;
        check("async reset busy", {31'd0, o_busy}, 32'd0);
        check("async reset done", {31'd0, o_done}, 32'd0);
        check("async reset result", o_result, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check("post-reset done", {31'd0, o_done}, 32'd0);
        do_op("divu max/1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        check("final done low", {31'd0, o_done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
